// File: rtl/banco_registros.sv
// banco_registros: fourteen-entry register bank fed by the Banco A write demux.
// One write port, two registered read ports with write-first forwarding,
// a sticky invalid-select flag and a synchronous clear of the whole bank.

module banco_registros #(
   parameter int WIDTH = 16,
   parameter int NREGS = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [3:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [3:0]       rd_sel_a,
   input  logic [3:0]       rd_sel_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid,
   output logic             err
);

   localparam logic [4:0] NSEL = 5'(NREGS);

   logic [WIDTH-1:0] regs [NREGS];
   logic             wr_ok;
   logic             sel_a_ok;
   logic             sel_b_ok;
   logic             bad_sel;
   logic [WIDTH-1:0] next_a;
   logic [WIDTH-1:0] next_b;

   // Classify each select as implemented or out of range, and flag misuse
   always_comb begin
      sel_a_ok = ({1'b0, rd_sel_a} < NSEL);
      sel_b_ok = ({1'b0, rd_sel_b} < NSEL);
      wr_ok    = wr_en && ({1'b0, wr_sel} < NSEL);
      bad_sel  = (wr_en && !wr_ok) || (rd_en && (!sel_a_ok || !sel_b_ok));
   end

   // Next read data: clear reads as zero, invalid select reads zero, a same-index write is forwarded
   always_comb begin
      next_a = '0;
      next_b = '0;
      if (!clr) begin
         if (sel_a_ok) begin
            next_a = (wr_ok && (wr_sel == rd_sel_a)) ? wr_data : regs[rd_sel_a];
         end
         if (sel_b_ok) begin
            next_b = (wr_ok && (wr_sel == rd_sel_b)) ? wr_data : regs[rd_sel_b];
         end
      end
   end

   // Register array: clear beats a same-cycle write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_sel] <= wr_data;
      end
   end

   // Read ports: load on request, otherwise hold; valid pulses with each request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data_a <= next_a;
            rd_data_b <= next_b;
         end
      end
   end

   // Sticky error flag, cleared only by clear or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (clr) begin
         err <= 1'b0;
      end else if (bad_sel) begin
         err <= 1'b1;
      end
   end

endmodule
